wb_regfile: RTL and testbench

- Consumer end of the writeback interface: accepts the registered writeback triple (data, address, enable) from the MEM/WB pipeline register and commits it to the architectural integer register file.
- Serves the two ID-stage read ports (rs1, rs2), with same-cycle writeback bypass.
- Keeps a per-register pending-write scoreboard. ID increments an entry when it issues a writer; a committed writeback decrements it. ID uses the resulting busy flags for interlock.

---
 rtl/wb_regfile_pkg.sv | 23 ++
 rtl/wb_regfile_if.sv | 32 +++
 rtl/wb_regfile_scoreboard.sv | 67 ++++++
 rtl/wb_regfile.sv | 71 +++++++
 tb/tb_wb_regfile.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_regfile_pkg.sv
// Shared configuration for the writeback register file slice.
package wb_regfile_pkg;

  localparam int unsigned RegLen     = 32;
  localparam int unsigned RegAddrLen = 5;
  localparam int unsigned PendLen    = 2;

  localparam logic [RegLen-1:0]     ZERO_WORD   = '0;
  localparam logic [RegAddrLen-1:0] RegAddrZero = '0;

  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;
  localparam logic ReadEnable   = 1'b1;
  localparam logic ReadDisable  = 1'b0;

  // Net effect of one edge on a single pending counter.
  typedef enum logic [1:0] {
    SB_HOLD = 2'd0,
    SB_INC  = 2'd1,
    SB_DEC  = 2'd2
  } sb_op_e;

endpackage

// File: rtl/wb_regfile_if.sv
// Writeback / issue / read-port bundle between the pipeline and the register file.
interface wb_regfile_if #(
  parameter int unsigned REG_LEN      = wb_regfile_pkg::RegLen,
  parameter int unsigned REG_ADDR_LEN = wb_regfile_pkg::RegAddrLen
);
  logic [REG_LEN-1:0]      wb_rd_data;
  logic [REG_ADDR_LEN-1:0] wb_rd_addr;
  logic                    wb_rd_enable;
  logic                    issue_enable;
  logic [REG_ADDR_LEN-1:0] issue_addr;
  logic                    rs1_read_enable;
  logic [REG_ADDR_LEN-1:0] rs1_addr;
  logic [REG_LEN-1:0]      rs1_data;
  logic                    rs1_busy;
  logic                    rs2_read_enable;
  logic [REG_ADDR_LEN-1:0] rs2_addr;
  logic [REG_LEN-1:0]      rs2_data;
  logic                    rs2_busy;
  logic                    pend_overflow;

  modport master (
    output wb_rd_data, wb_rd_addr, wb_rd_enable, issue_enable, issue_addr,
    output rs1_read_enable, rs1_addr, rs2_read_enable, rs2_addr,
    input  rs1_data, rs1_busy, rs2_data, rs2_busy, pend_overflow
  );

  modport slave (
    input  wb_rd_data, wb_rd_addr, wb_rd_enable, issue_enable, issue_addr,
    input  rs1_read_enable, rs1_addr, rs2_read_enable, rs2_addr,
    output rs1_data, rs1_busy, rs2_data, rs2_busy, pend_overflow
  );
endinterface

// File: rtl/wb_regfile_scoreboard.sv
// Per-register pending-write counters with saturating increment,
// non-underflowing decrement and a sticky overflow flag.
module regfile_scoreboard
  import wb_regfile_pkg::*;
#(
  parameter int unsigned REG_ADDR_LEN = RegAddrLen,
  parameter int unsigned PEND_W       = PendLen
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    inc_enable,
  input  logic [REG_ADDR_LEN-1:0] inc_addr,
  input  logic                    dec_enable,
  input  logic [REG_ADDR_LEN-1:0] dec_addr,
  input  logic [REG_ADDR_LEN-1:0] rs1_addr,
  input  logic [REG_ADDR_LEN-1:0] rs2_addr,
  output logic                    rs1_pending,
  output logic                    rs2_pending,
  output logic                    overflow
);

  localparam int unsigned NumRegs = 2 ** REG_ADDR_LEN;
  localparam logic [PEND_W-1:0] PendMax = '1;

  logic [PEND_W-1:0] pend [NumRegs];
  sb_op_e            op   [NumRegs];
  logic              inc, dec;

  // Writes to x0 never enter the scoreboard, so pend[0] stays zero.
  assign inc = inc_enable && (inc_addr != '0);
  assign dec = dec_enable && (dec_addr != '0);

  // Resolve each counter's action; an issue and a writeback on the same register cancel.
  always_comb begin
    for (int unsigned i = 0; i < NumRegs; i++) begin
      op[i] = SB_HOLD;
      if (inc && inc_addr == REG_ADDR_LEN'(i) && !(dec && dec_addr == REG_ADDR_LEN'(i)))
        op[i] = SB_INC;
      else if (dec && dec_addr == REG_ADDR_LEN'(i) && !(inc && inc_addr == REG_ADDR_LEN'(i)))
        op[i] = SB_DEC;
    end
  end

  // Counter array and sticky overflow, frozen while rdy is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NumRegs; i++) pend[i] <= '0;
      overflow <= 1'b0;
    end else if (rdy) begin
      for (int unsigned i = 0; i < NumRegs; i++) begin
        case (op[i])
          SB_INC: begin
            if (pend[i] == PendMax) overflow <= 1'b1;
            else                    pend[i]  <= pend[i] + 1'b1;
          end
          SB_DEC: if (pend[i] != '0) pend[i] <= pend[i] - 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign rs1_pending = (pend[rs1_addr] != '0);
  assign rs2_pending = (pend[rs2_addr] != '0);

endmodule

// File: rtl/wb_regfile.sv
// Architectural integer register file: writeback commit, two bypassed
// read ports and busy flags from the pending-write scoreboard.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int unsigned REG_LEN      = RegLen,
  parameter int unsigned REG_ADDR_LEN = RegAddrLen,
  parameter int unsigned PEND_W       = PendLen
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rdy,
  wb_regfile_if.slave  bus
);

  localparam int unsigned NumRegs = 2 ** REG_ADDR_LEN;

  logic [REG_LEN-1:0] regs [NumRegs];
  logic               wr_commit;
  logic               rs1_pending, rs2_pending;

  assign wr_commit = rdy && (bus.wb_rd_enable == WriteEnable) && (bus.wb_rd_addr != '0);

  // Commit the writeback triple; x0 is never written.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NumRegs; i++) regs[i] <= '0;
    end else if (wr_commit) begin
      regs[bus.wb_rd_addr] <= bus.wb_rd_data;
    end
  end

  function automatic logic [REG_LEN-1:0] read_port(
    input logic                    en,
    input logic [REG_ADDR_LEN-1:0] addr
  );
    if (en != ReadEnable || addr == '0)
      return '0;
    // Bypass ignores rdy so ID sees the in-flight value even while stalled.
    if (bus.wb_rd_enable == WriteEnable && bus.wb_rd_addr == addr)
      return bus.wb_rd_data;
    return regs[addr];
  endfunction

  // Zero-latency read ports with same-cycle writeback bypass.
  always_comb begin
    bus.rs1_data = read_port(bus.rs1_read_enable, bus.rs1_addr);
    bus.rs2_data = read_port(bus.rs2_read_enable, bus.rs2_addr);
    bus.rs1_busy = (bus.rs1_read_enable == ReadEnable) && rs1_pending;
    bus.rs2_busy = (bus.rs2_read_enable == ReadEnable) && rs2_pending;
  end

  regfile_scoreboard #(
    .REG_ADDR_LEN (REG_ADDR_LEN),
    .PEND_W       (PEND_W)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .rdy         (rdy),
    .inc_enable  (bus.issue_enable),
    .inc_addr    (bus.issue_addr),
    .dec_enable  (bus.wb_rd_enable),
    .dec_addr    (bus.wb_rd_addr),
    .rs1_addr    (bus.rs1_addr),
    .rs2_addr    (bus.rs2_addr),
    .rs1_pending (rs1_pending),
    .rs2_pending (rs2_pending),
    .overflow    (bus.pend_overflow)
  );

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: reset, write/bypass, x0, scoreboard,
// saturation, rdy gating and mid-run reset.
module tb_wb_regfile;
  import wb_regfile_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rdy = 1'b1;
  int   checks = 0;
  int   errors = 0;

  wb_regfile_if #(.REG_LEN(32), .REG_ADDR_LEN(5)) bus ();

  wb_regfile #(.REG_LEN(32), .REG_ADDR_LEN(5), .PEND_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic idle();
    bus.wb_rd_data      = '0;
    bus.wb_rd_addr      = '0;
    bus.wb_rd_enable    = 1'b0;
    bus.issue_enable    = 1'b0;
    bus.issue_addr      = '0;
    bus.rs1_read_enable = 1'b0;
    bus.rs1_addr        = '0;
    bus.rs2_read_enable = 1'b0;
    bus.rs2_addr        = '0;
    rdy                 = 1'b1;
  endtask

  // Advance one rising edge and settle 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd1(input logic [4:0] a);
    bus.rs1_read_enable = 1'b1;
    bus.rs1_addr        = a;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    bus.wb_rd_enable = 1'b1;
    bus.wb_rd_addr   = a;
    bus.wb_rd_data   = d;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b0;
    #12;
    rst = 1'b1;
    #2;
    rd1(5'd5);
    bus.rs2_read_enable = 1'b1;
    bus.rs2_addr        = 5'd31;
    #1;
    checks++; if (bus.rs1_data !== 32'h0) begin errors++; $display("FAIL reset_rs1_data got %h exp %h", bus.rs1_data, 32'h0); end
    checks++; if (bus.rs1_busy !== 1'b0) begin errors++; $display("FAIL reset_rs1_busy got %b exp 0", bus.rs1_busy); end
    checks++; if (bus.rs2_data !== 32'h0) begin errors++; $display("FAIL reset_rs2_data got %h exp %h", bus.rs2_data, 32'h0); end
    checks++; if (bus.rs2_busy !== 1'b0) begin errors++; $display("FAIL reset_rs2_busy got %b exp 0", bus.rs2_busy); end
    checks++; if (bus.pend_overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", bus.pend_overflow); end
  endtask

  task automatic test_write_read();
    idle();
    step();
    wb(5'd3, 32'hDEADBEEF);
    bus.rs2_read_enable = 1'b1;
    bus.rs2_addr        = 5'd3;
    #1;
    checks++; if (bus.rs2_data !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_rs2 got %h exp %h", bus.rs2_data, 32'hDEADBEEF); end
    step();
    bus.wb_rd_enable = 1'b0;
    rd1(5'd3);
    #1;
    checks++; if (bus.rs1_data !== 32'hDEADBEEF) begin errors++; $display("FAIL stored_rs1 got %h exp %h", bus.rs1_data, 32'hDEADBEEF); end
    bus.rs1_read_enable = 1'b0;
    #1;
    checks++; if (bus.rs1_data !== 32'h0) begin errors++; $display("FAIL read_disabled got %h exp %h", bus.rs1_data, 32'h0); end
    // Write to another register must not disturb x3.
    wb(5'd8, 32'h0BADF00D);
    step();
    idle();
    rd1(5'd3);
    #1;
    checks++; if (bus.rs1_data !== 32'hDEADBEEF) begin errors++; $display("FAIL x3_kept got %h exp %h", bus.rs1_data, 32'hDEADBEEF); end
  endtask

  task automatic test_x0();
    idle();
    wb(5'd0, 32'h12345678);
    bus.issue_enable = 1'b1;
    bus.issue_addr   = 5'd0;
    rd1(5'd0);
    #1;
    checks++; if (bus.rs1_data !== 32'h0) begin errors++; $display("FAIL x0_bypass got %h exp %h", bus.rs1_data, 32'h0); end
    step();
    idle();
    rd1(5'd0);
    #1;
    checks++; if (bus.rs1_data !== 32'h0) begin errors++; $display("FAIL x0_data got %h exp %h", bus.rs1_data, 32'h0); end
    checks++; if (bus.rs1_busy !== 1'b0) begin errors++; $display("FAIL x0_busy got %b exp 0", bus.rs1_busy); end
  endtask

  task automatic test_scoreboard();
    idle();
    rd1(5'd7);
    bus.issue_enable = 1'b1;
    bus.issue_addr   = 5'd7;
    step();
    step();
    bus.issue_enable = 1'b0;
    #1;
    checks++; if (bus.rs1_busy !== 1'b1) begin errors++; $display("FAIL sb_after_issue got %b exp 1", bus.rs1_busy); end
    wb(5'd7, 32'h00000077);
    step();
    bus.wb_rd_enable = 1'b0;
    #1;
    checks++; if (bus.rs1_busy !== 1'b1) begin errors++; $display("FAIL sb_one_left got %b exp 1", bus.rs1_busy); end
    wb(5'd7, 32'h00000777);
    #1;
    checks++; if (bus.rs1_busy !== 1'b1) begin errors++; $display("FAIL sb_wb_cycle_busy got %b exp 1", bus.rs1_busy); end
    checks++; if (bus.rs1_data !== 32'h00000777) begin errors++; $display("FAIL sb_wb_cycle_data got %h exp %h", bus.rs1_data, 32'h00000777); end
    step();
    bus.wb_rd_enable = 1'b0;
    #1;
    checks++; if (bus.rs1_busy !== 1'b0) begin errors++; $display("FAIL sb_drained got %b exp 0", bus.rs1_busy); end
    // Count 1, then simultaneous issue+wb keeps it at 1; one more wb drains it.
    bus.issue_enable = 1'b1;
    step();
    wb(5'd7, 32'h1);
    step();
    idle();
    rd1(5'd7);
    #1;
    checks++; if (bus.rs1_busy !== 1'b1) begin errors++; $display("FAIL sb_same_addr got %b exp 1", bus.rs1_busy); end
    wb(5'd7, 32'h2);
    step();
    bus.wb_rd_enable = 1'b0;
    #1;
    checks++; if (bus.rs1_busy !== 1'b0) begin errors++; $display("FAIL sb_same_addr_drain got %b exp 0", bus.rs1_busy); end
    // Issue and wb on different registers both apply.
    bus.issue_enable = 1'b1;
    bus.issue_addr   = 5'd11;
    step();
    bus.issue_addr   = 5'd12;
    wb(5'd11, 32'h3);
    step();
    idle();
    rd1(5'd11);
    bus.rs2_read_enable = 1'b1;
    bus.rs2_addr        = 5'd12;
    #1;
    checks++; if (bus.rs1_busy !== 1'b0) begin errors++; $display("FAIL sb_diff_dec got %b exp 0", bus.rs1_busy); end
    checks++; if (bus.rs2_busy !== 1'b1) begin errors++; $display("FAIL sb_diff_inc got %b exp 1", bus.rs2_busy); end
    wb(5'd12, 32'h4);
    step();
    idle();
  endtask

  task automatic test_saturation();
    idle();
    rd1(5'd9);
    bus.issue_enable = 1'b1;
    bus.issue_addr   = 5'd9;
    for (int i = 0; i < 3; i++) step();
    checks++; if (bus.pend_overflow !== 1'b0) begin errors++; $display("FAIL sat_no_ovf_at3 got %b exp 0", bus.pend_overflow); end
    step();
    bus.issue_enable = 1'b0;
    #1;
    checks++; if (bus.pend_overflow !== 1'b1) begin errors++; $display("FAIL sat_ovf got %b exp 1", bus.pend_overflow); end
    wb(5'd9, 32'h9);
    step();
    step();
    #1;
    checks++; if (bus.rs1_busy !== 1'b1) begin errors++; $display("FAIL sat_count_held got %b exp 1", bus.rs1_busy); end
    step();
    bus.wb_rd_enable = 1'b0;
    #1;
    checks++; if (bus.rs1_busy !== 1'b0) begin errors++; $display("FAIL sat_drained got %b exp 0", bus.rs1_busy); end
    // Underflow: wb at count 0, then one issue + one wb must drain fully.
    wb(5'd9, 32'h9);
    step();
    idle();
    rd1(5'd9);
    #1;
    checks++; if (bus.rs1_busy !== 1'b0) begin errors++; $display("FAIL underflow_busy got %b exp 0", bus.rs1_busy); end
    checks++; if (bus.pend_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", bus.pend_overflow); end
    bus.issue_enable = 1'b1;
    bus.issue_addr   = 5'd9;
    step();
    bus.issue_enable = 1'b0;
    wb(5'd9, 32'h9);
    step();
    bus.wb_rd_enable = 1'b0;
    #1;
    checks++; if (bus.rs1_busy !== 1'b0) begin errors++; $display("FAIL underflow_no_wrap got %b exp 0", bus.rs1_busy); end
  endtask

  task automatic test_rdy();
    idle();
    rdy = 1'b0;
    wb(5'd4, 32'hA5A5A5A5);
    bus.issue_enable = 1'b1;
    bus.issue_addr   = 5'd4;
    rd1(5'd4);
    #1;
    checks++; if (bus.rs1_data !== 32'hA5A5A5A5) begin errors++; $display("FAIL rdy_bypass got %h exp %h", bus.rs1_data, 32'hA5A5A5A5); end
    step();
    bus.wb_rd_enable = 1'b0;
    bus.issue_enable = 1'b0;
    #1;
    checks++; if (bus.rs1_data !== 32'h0) begin errors++; $display("FAIL rdy_no_write got %h exp %h", bus.rs1_data, 32'h0); end
    checks++; if (bus.rs1_busy !== 1'b0) begin errors++; $display("FAIL rdy_no_issue got %b exp 0", bus.rs1_busy); end
    idle();
  endtask

  task automatic test_reset_mid();
    idle();
    bus.issue_enable = 1'b1;
    bus.issue_addr   = 5'd10;
    step();
    idle();
    #2;
    rst = 1'b0;
    #1;
    rd1(5'd3);
    #1;
    checks++; if (bus.rs1_data !== 32'h0) begin errors++; $display("FAIL async_rst_data got %h exp %h", bus.rs1_data, 32'h0); end
    checks++; if (bus.pend_overflow !== 1'b0) begin errors++; $display("FAIL async_rst_ovf got %b exp 0", bus.pend_overflow); end
    step();
    rst = 1'b1;
    rd1(5'd10);
    #1;
    checks++; if (bus.rs1_busy !== 1'b0) begin errors++; $display("FAIL rst_busy_lost got %b exp 0", bus.rs1_busy); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_x0();
    test_scoreboard();
    test_saturation();
    test_rdy();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
